// File: rtl/che_line_buffer_mc.sv
// rtl/che_line_buffer_mc.sv - multi-line pixel FIFO buffer with per-line status
//
// LINE_NUM independent FIFO lines, each LINE_DEPTH x DAT_WD, addressed per access
// by a line number. One write and one read per cycle, on any mix of lines.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   clr_i           synchronous flush of pointers, levels and sticky flags
//   wr_en_i/wr_num_i/wr_dat_i   write request, target line, data
//   rd_en_i/rd_num_i            read request, source line
//   vld_o/dat_o     registered read data, valid one cycle after an accepted read
//   full_o/empty_o  per-line status bits
//   lvl_o           per-line fill level, line i in [i*CNT_WD +: CNT_WD]
//   ovf_o/udf_o     sticky dropped-write / rejected-read flags
module che_line_buffer_mc #(
  parameter int DAT_WD     = 10,
  parameter int LINE_NUM   = 3,
  parameter int LINE_DEPTH = 1024,
  parameter int NUM_WD     = $clog2(LINE_NUM),
  parameter int CNT_WD     = $clog2(LINE_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr_i,
  input  logic                       wr_en_i,
  input  logic [NUM_WD-1:0]          wr_num_i,
  input  logic [DAT_WD-1:0]          wr_dat_i,
  input  logic                       rd_en_i,
  input  logic [NUM_WD-1:0]          rd_num_i,
  output logic                       vld_o,
  output logic [DAT_WD-1:0]          dat_o,
  output logic [LINE_NUM-1:0]        full_o,
  output logic [LINE_NUM-1:0]        empty_o,
  output logic [LINE_NUM*CNT_WD-1:0] lvl_o,
  output logic                       ovf_o,
  output logic                       udf_o
);

  localparam int PTR_WD = $clog2(LINE_DEPTH);

  logic [DAT_WD-1:0] mem  [LINE_NUM][LINE_DEPTH];
  logic [PTR_WD-1:0] wptr [LINE_NUM];
  logic [PTR_WD-1:0] rptr [LINE_NUM];
  logic [CNT_WD-1:0] cnt  [LINE_NUM];

  logic                wr_in_rng;
  logic                rd_in_rng;
  logic                rd_ok;
  logic                wr_ok;
  logic [LINE_NUM-1:0] wr_sel;
  logic [LINE_NUM-1:0] rd_sel;

  // Read acceptance uses the level before this cycle's write, so a word is never
  // bypassed from the write port to the read port in the same cycle. A write to a
  // full line still goes in when the same line is read in that cycle.
  always_comb begin
    wr_in_rng = int'(wr_num_i) < LINE_NUM;
    rd_in_rng = int'(rd_num_i) < LINE_NUM;
    rd_ok     = rd_en_i && rd_in_rng && (cnt[rd_num_i] != '0);
    wr_ok     = wr_en_i && wr_in_rng &&
                ((cnt[wr_num_i] != CNT_WD'(LINE_DEPTH)) ||
                 (rd_ok && (rd_num_i == wr_num_i)));
    wr_sel    = '0;
    rd_sel    = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      wr_sel[i] = wr_ok && (int'(wr_num_i) == i);
      rd_sel[i] = rd_ok && (int'(rd_num_i) == i);
    end
  end

  always_comb begin
    full_o  = '0;
    empty_o = '0;
    lvl_o   = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      full_o[i]                  = (cnt[i] == CNT_WD'(LINE_DEPTH));
      empty_o[i]                 = (cnt[i] == '0);
      lvl_o[i*CNT_WD +: CNT_WD]  = cnt[i];
    end
  end

  // Storage is deliberately not reset or flushed; pointers alone define content.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr_i) begin
      mem[wr_num_i][wptr[wr_num_i]] <= wr_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      vld_o <= 1'b0;
      dat_o <= '0;
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      vld_o <= 1'b0;
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      vld_o <= rd_ok;
      if (rd_ok) begin
        dat_o <= mem[rd_num_i][rptr[rd_num_i]];
      end
      if (wr_en_i && !wr_ok) begin
        ovf_o <= 1'b1;
      end
      if (rd_en_i && !rd_ok) begin
        udf_o <= 1'b1;
      end
      for (int i = 0; i < LINE_NUM; i++) begin
        if (wr_sel[i]) begin
          wptr[i] <= wptr[i] + PTR_WD'(1);
        end
        if (rd_sel[i]) begin
          rptr[i] <= rptr[i] + PTR_WD'(1);
        end
        if (wr_sel[i] && !rd_sel[i]) begin
          cnt[i] <= cnt[i] + CNT_WD'(1);
        end else if (rd_sel[i] && !wr_sel[i]) begin
          cnt[i] <= cnt[i] - CNT_WD'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_che_line_buffer_mc.sv
// tb/tb_che_line_buffer_mc.sv - randomized self-checking bench for che_line_buffer_mc
module tb_che_line_buffer_mc;

  localparam int DW = 10;
  localparam int LN = 3;
  localparam int LD = 4;
  localparam int NW = 2;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            clr_i;
  logic            wr_en_i;
  logic [NW-1:0]   wr_num_i;
  logic [DW-1:0]   wr_dat_i;
  logic            rd_en_i;
  logic [NW-1:0]   rd_num_i;
  logic            vld_o;
  logic [DW-1:0]   dat_o;
  logic [LN-1:0]   full_o;
  logic [LN-1:0]   empty_o;
  logic [LN*CW-1:0] lvl_o;
  logic            ovf_o;
  logic            udf_o;

  always #5 clk = ~clk;

  che_line_buffer_mc #(
    .DAT_WD(DW), .LINE_NUM(LN), .LINE_DEPTH(LD), .NUM_WD(NW), .CNT_WD(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .clr_i(clr_i),
    .wr_en_i(wr_en_i), .wr_num_i(wr_num_i), .wr_dat_i(wr_dat_i),
    .rd_en_i(rd_en_i), .rd_num_i(rd_num_i),
    .vld_o(vld_o), .dat_o(dat_o), .full_o(full_o), .empty_o(empty_o),
    .lvl_o(lvl_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per line plus the visible output registers.
  int          q [LN][$];
  logic        m_vld;
  logic [DW-1:0] m_dat;
  logic        m_ovf;
  logic        m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LN; i++) q[i].delete();
    m_vld = 1'b0;
    m_dat = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic we, input int wn, input int wd,
                            input logic re, input int rn, input logic cl);
    logic rok;
    logic wok;
    if (cl) begin
      for (int i = 0; i < LN; i++) q[i].delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rok = 1'b0;
      if (re && rn < LN) begin
        if (q[rn].size() > 0) rok = 1'b1;
      end
      wok = 1'b0;
      if (we && wn < LN) begin
        if (q[wn].size() < LD || (rok && rn == wn)) wok = 1'b1;
      end
      if (rok) m_dat = DW'(q[rn].pop_front());
      m_vld = rok;
      if (wok) q[wn].push_back(wd % (1 << DW));
      if (we && !wok) m_ovf = 1'b1;
      if (re && !rok) m_udf = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":vld"}, 32'(vld_o), 32'(m_vld));
    chk({ph, ":dat"}, 32'(dat_o), 32'(m_dat));
    chk({ph, ":ovf"}, 32'(ovf_o), 32'(m_ovf));
    chk({ph, ":udf"}, 32'(udf_o), 32'(m_udf));
    for (int i = 0; i < LN; i++) begin
      chk($sformatf("%s:lvl%0d", ph, i), 32'(lvl_o[i*CW +: CW]), 32'(q[i].size()));
      chk($sformatf("%s:full%0d", ph, i), 32'(full_o[i]), 32'(q[i].size() == LD));
      chk($sformatf("%s:empty%0d", ph, i), 32'(empty_o[i]), 32'(q[i].size() == 0));
    end
  endtask

  task automatic idle_inputs();
    clr_i = 1'b0; wr_en_i = 1'b0; wr_num_i = '0; wr_dat_i = '0;
    rd_en_i = 1'b0; rd_num_i = '0;
  endtask

  task automatic cycle(input string ph, input logic we, input int wn, input int wd,
                       input logic re, input int rn, input logic cl);
    wr_en_i  = we;
    wr_num_i = NW'(wn);
    wr_dat_i = DW'(wd);
    rd_en_i  = re;
    rd_num_i = NW'(rn);
    clr_i    = cl;
    @(posedge clk);
    #1;
    model_step(we, wn, wd, re, rn, cl);
    check_all(ph);
    idle_inputs();
  endtask

  task automatic wr(input string ph, input int wn, input int wd);
    cycle(ph, 1'b1, wn, wd, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input string ph, input int rn);
    cycle(ph, 1'b0, 0, 0, 1'b1, rn, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    rstn = 1'b1;

    // Basic write/read on line 1.
    wr("w1", 1, 'h011);
    wr("w1", 1, 'h012);
    wr("w1", 1, 'h013);
    chk("l1_lvl3", 32'(lvl_o[CW +: CW]), 32'd3);
    chk("l1_empty", 32'(empty_o), 32'b101);
    rd("r1", 1);
    chk("r1_first", 32'(dat_o), 32'h011);
    rd("r1", 1);
    rd("r1", 1);
    chk("r1_last", 32'(dat_o), 32'h013);
    cycle("r1idle", 1'b0, 0, 0, 1'b0, 0, 1'b0);
    chk("r1_vld_drop", 32'(vld_o), 32'd0);

    // Overflow of line 2.
    for (int k = 0; k < 4; k++) wr("w2", 2, 'h100 + k);
    wr("w2ovf", 2, 'h3FF);
    chk("l2_full", 32'(full_o[2]), 32'd1);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    for (int k = 0; k < 4; k++) rd("r2", 2);
    chk("l2_tail", 32'(dat_o), 32'h103);

    // Underflow on empty line 0, then write+read on empty line 0.
    rd("udf", 0);
    chk("udf_set", 32'(udf_o), 32'd1);
    cycle("wr_rd_empty", 1'b1, 0, 'h2AA, 1'b1, 0, 1'b0);
    chk("l0_lvl1", 32'(lvl_o[0 +: CW]), 32'd1);
    rd("drain0", 0);

    // Out-of-range line number on both ports.
    cycle("oor", 1'b1, 3, 'h111, 1'b1, 3, 1'b0);

    // Full line, simultaneous write and read.
    for (int k = 0; k < 4; k++) wr("fill2", 2, 'h040 + k);
    cycle("full_wr_rd", 1'b1, 2, 'h155, 1'b1, 2, 1'b0);
    chk("full_lvl", 32'(lvl_o[2*CW +: CW]), 32'd4);
    for (int k = 0; k < 4; k++) rd("r155", 2);
    chk("tail155", 32'(dat_o), 32'h155);

    // Pointer wrap on line 0 from a flushed state.
    cycle("clr0", 1'b0, 0, 0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      wr("wrap_w", 0, k);
      rd("wrap_r", 0);
      chk($sformatf("wrap_dat%0d", k), 32'(dat_o), 32'(k));
    end
    chk("wrap_noflag", 32'({ovf_o, udf_o}), 32'd0);

    // Flush dominates a same-cycle write.
    wr("pf", 0, 'h021);
    wr("pf", 1, 'h022);
    wr("pf", 1, 'h023);
    cycle("pfovf", 1'b1, 3, 0, 1'b0, 0, 1'b0);
    cycle("clrwr", 1'b1, 0, 'h099, 1'b1, 1, 1'b1);
    chk("clr_empty", 32'(empty_o), 32'b111);
    chk("clr_ovf", 32'(ovf_o), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1023)), 1'($urandom_range(0, 2) != 0),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 3; k++) wr("prerst", k, 'h200 + k);
    rd("prerst", 1);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rstn = 1'b1;
    rd("post_rst", 0);
    wr("post_rst", 2, 'h0AB);
    rd("post_rst", 2);
    chk("post_rst_dat", 32'(dat_o), 32'h0AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
